// File: rtl/bcd_upcount_timer.sv
// Two-digit BCD up-counting timer with IDLE/RUN/PAUSE/DONE control and optional wrap.
// Define BCD_TIMER_SEG_EN to drive the active-low seven-segment digit outputs.
module bcd_upcount_timer #(
  parameter int LIMIT = 59,
  parameter bit WRAP  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       clear_i,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic [6:0] count_bin_o,
  output logic [1:0] state_o,
  output logic       done_o,
  output logic       wrap_o,
  output logic [6:0] seg_ones_o,
  output logic [6:0] seg_tens_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LIM_TENS = 4'(LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(LIMIT % 10);

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] bin_q, bin_d;
  logic       done_q;
  logic       wrap_q, wrap_d;
  logic       at_limit;
  logic       resume;

  assign at_limit = (tens_q == LIM_TENS) && (ones_q == LIM_ONES);
  // A simultaneous stop cancels a start outside RUN.
  assign resume   = start_i && !stop_i;

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      bin_d   = 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (resume) state_d = RUN;
        end
        RUN: begin
          if (stop_i) begin
            state_d = PAUSE;
          end else if (tick_i) begin
            if (at_limit) begin
              if (WRAP) begin
                ones_d = 4'd0;
                tens_d = 4'd0;
                bin_d  = 7'd0;
                wrap_d = 1'b1;
              end else begin
                state_d = DONE;
              end
            end else begin
              bin_d = bin_q + 7'd1;
              if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
          end
        end
        PAUSE: begin
          if (resume) state_d = RUN;
        end
        DONE: begin
          if (resume) begin
            state_d = RUN;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            bin_d   = 7'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      bin_q   <= 7'd0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      bin_q   <= bin_d;
      done_q  <= (state_d == DONE);
      wrap_q  <= wrap_d;
    end
  end

  assign ones_o      = ones_q;
  assign tens_o      = tens_q;
  assign count_bin_o = bin_q;
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

`ifdef BCD_TIMER_SEG_EN
  // Active-low, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign seg_ones_o = seg_decode(ones_q);
  assign seg_tens_o = seg_decode(tens_q);
`else
  assign seg_ones_o = 7'h7F;
  assign seg_tens_o = 7'h7F;
`endif

endmodule

// File: tb/tb_bcd_upcount_timer.sv
// Scoreboard bench: four timer configurations share one random/directed stimulus stream.
module tb_bcd_upcount_timer;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] st;
    logic [6:0] cnt;
    logic       wr;
  } one_t;
  typedef one_t [N-1:0] exp_t;

  logic clock;
  logic reset;
  logic tick, start, stop, clear;

  logic [3:0] ones_w   [N];
  logic [3:0] tens_w   [N];
  logic [6:0] bin_w    [N];
  logic [1:0] state_w  [N];
  logic       done_w   [N];
  logic       wrap_w   [N];
  logic [6:0] sego_w   [N];
  logic [6:0] segt_w   [N];

  int lim  [N] = '{59, 59, 7, 12};
  bit wcfg [N] = '{1'b0, 1'b1, 1'b1, 1'b0};

  int m_st  [N];
  int m_cnt [N];
  bit m_wr  [N];

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  bcd_upcount_timer #(.LIMIT(59), .WRAP(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .tick_i(tick), .start_i(start), .stop_i(stop), .clear_i(clear),
    .ones_o(ones_w[0]), .tens_o(tens_w[0]), .count_bin_o(bin_w[0]), .state_o(state_w[0]),
    .done_o(done_w[0]), .wrap_o(wrap_w[0]), .seg_ones_o(sego_w[0]), .seg_tens_o(segt_w[0]));
  bcd_upcount_timer #(.LIMIT(59), .WRAP(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .tick_i(tick), .start_i(start), .stop_i(stop), .clear_i(clear),
    .ones_o(ones_w[1]), .tens_o(tens_w[1]), .count_bin_o(bin_w[1]), .state_o(state_w[1]),
    .done_o(done_w[1]), .wrap_o(wrap_w[1]), .seg_ones_o(sego_w[1]), .seg_tens_o(segt_w[1]));
  bcd_upcount_timer #(.LIMIT(7), .WRAP(1'b1)) u_dut2 (
    .clock(clock), .reset(reset), .tick_i(tick), .start_i(start), .stop_i(stop), .clear_i(clear),
    .ones_o(ones_w[2]), .tens_o(tens_w[2]), .count_bin_o(bin_w[2]), .state_o(state_w[2]),
    .done_o(done_w[2]), .wrap_o(wrap_w[2]), .seg_ones_o(sego_w[2]), .seg_tens_o(segt_w[2]));
  bcd_upcount_timer #(.LIMIT(12), .WRAP(1'b0)) u_dut3 (
    .clock(clock), .reset(reset), .tick_i(tick), .start_i(start), .stop_i(stop), .clear_i(clear),
    .ones_o(ones_w[3]), .tens_o(tens_w[3]), .count_bin_o(bin_w[3]), .state_o(state_w[3]),
    .done_o(done_w[3]), .wrap_o(wrap_w[3]), .seg_ones_o(sego_w[3]), .seg_tens_o(segt_w[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int seg_ref(input int d);
    logic [6:0] glyph [10];
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef BCD_TIMER_SEG_EN
    return (d >= 0 && d <= 9) ? int'(glyph[d]) : 'h7F;
`else
    return 'h7F;
`endif
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Timer behaviour in plain integers: states 0=IDLE 1=RUN 2=PAUSE 3=DONE.
  task automatic model(input int k, input bit tk, st, sp, cl, rs);
    m_wr[k] = 1'b0;
    if (rs || cl) begin
      m_st[k]  = 0;
      m_cnt[k] = 0;
    end else if (m_st[k] == 1) begin
      if (sp) m_st[k] = 2;
      else if (tk) begin
        if (m_cnt[k] < lim[k]) m_cnt[k] = m_cnt[k] + 1;
        else if (wcfg[k]) begin
          m_cnt[k] = 0;
          m_wr[k]  = 1'b1;
        end else m_st[k] = 3;
      end
    end else if (st && !sp) begin
      if (m_st[k] == 3) m_cnt[k] = 0;
      m_st[k] = 1;
    end
  endtask

  task automatic step(input bit tk, st, sp, cl, rs, input bit async_chk);
    exp_t e;
    @(negedge clock);
    tick = tk; start = st; stop = sp; clear = cl; reset = rs;
    for (int k = 0; k < N; k++) begin
      model(k, tk, st, sp, cl, rs);
      e[k].st  = m_st[k][1:0];
      e[k].cnt = 7'(m_cnt[k]);
      e[k].wr  = m_wr[k];
    end
    sb_q.push_back(e);
    if (async_chk) begin
      #1;
      for (int k = 0; k < N; k++) begin
        chk("async_state", k, int'(state_w[k]), 0);
        chk("async_ones",  k, int'(ones_w[k]),  0);
        chk("async_tens",  k, int'(tens_w[k]),  0);
        chk("async_bin",   k, int'(bin_w[k]),   0);
        chk("async_done",  k, int'(done_w[k]),  0);
        chk("async_wrap",  k, int'(wrap_w[k]),  0);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per active edge, compared 1 time unit after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int k = 0; k < N; k++) begin
          chk("state",     k, int'(state_w[k]), int'(e[k].st));
          chk("ones",      k, int'(ones_w[k]),  int'(e[k].cnt) % 10);
          chk("tens",      k, int'(tens_w[k]),  int'(e[k].cnt) / 10);
          chk("count_bin", k, int'(bin_w[k]),   int'(e[k].cnt));
          chk("done",      k, int'(done_w[k]),  (e[k].st == 2'd3) ? 1 : 0);
          chk("wrap",      k, int'(wrap_w[k]),  int'(e[k].wr));
          chk("seg_ones",  k, int'(sego_w[k]),  seg_ref(int'(e[k].cnt) % 10));
          chk("seg_tens",  k, int'(segt_w[k]),  seg_ref(int'(e[k].cnt) / 10));
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_wr[k] = 1'b0;
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);          // tick in IDLE is ignored
    step(0, 1, 0, 0, 0, 0);
    ticks(12);                       // 12 ticks -> 12
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);          // start+tick only changes state
    ticks(63);                       // terminal count, DONE / wrap, extra ticks
    step(0, 0, 1, 0, 0, 0);          // stop ignored in DONE
    step(1, 1, 0, 0, 0, 0);          // DONE -> RUN at 0
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    ticks(7);
    step(1, 0, 1, 0, 0, 0);          // stop+tick: PAUSE, tick dropped
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);          // start+stop outside RUN: nothing
    step(0, 1, 0, 0, 0, 0);
    ticks(3);                        // 8, 9, 10
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    ticks(33);
    step(1, 1, 0, 1, 0, 0);          // clear beats start and tick
    step(0, 1, 0, 0, 0, 0);
    ticks(5);
    step(0, 0, 0, 0, 1, 1);          // asynchronous reset mid-RUN
    step(1, 0, 0, 0, 0, 0);          // first edge after release acts as IDLE
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 100) < 60, ($urandom % 100) < 12, ($urandom % 100) < 6,
           ($urandom % 100) < 2, ($urandom % 1000) < 5, 1'b0);
    end
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
    #2;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
